window_filter_stream: RTL and testbench
=======================================

# window_filter_stream

Parametrised streaming 3x3 window filter that replaces the fixed 9-tap memory/controller/filter trio with one raster-order pixel stream engine. Internal line buffers build the 3x3 neighbourhood on the fly, and a run-time mode selects the operator: Gaussian, min, max or bypass. The block sits between the pixel source and the result sink of the image pipeline. It emits exactly one output pixel per input pixel, in raster order, with self-generated flush at end of frame.

## Interface
- DATA_W, 8, pixel width in bits
- IMG_W, 64, frame width in pixels (≥3)
- IMG_H, 64, frame height in pixels (≥3)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  frame start pulse; honoured only in IDLE
- mode  in  2  0=GAUSS, 1=MIN, 2=MAX, 3=BYPASS; sampled on accepted start
- in_valid  in  1  in_pixel valid this cycle; gaps allowed
- in_pixel  in  DATA_W  raster-order input pixel
- out_valid  out  1  out_pixel valid, one-cycle strobe
- out_pixel  out  DATA_W  filtered pixel, raster order
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse, cycle after final out_valid

## Operation
- All outputs reset to 0. State resets to IDLE, and all counters and the mode register clear.
- States:
  - IDLE: start → RUN.
  - RUN: accepts in_valid pixels; after the IMG_W·IMG_H-th accepted pixel → FLUSH.
  - FLUSH: runs IMG_W+1 internal advance cycles, one per clock, with in_valid ignored → DONE.
  - DONE: pulses done for one cycle → IDLE.
- Window: two line buffers of IMG_W·DATA_W plus a 3x3 register window, advanced on each accepted pixel or flush cycle.
- Output (r,c) is produced by the advance that accepts input index r·IMG_W+c+IMG_W+1. The last IMG_W+1 outputs come from FLUSH.
- Border pixels (r=0, r=IMG_H-1, c=0, c=IMG_W-1) output the centre pixel unchanged in every mode. No wrap-around mixing across row edges.
- Interior pixels:
  - GAUSS: weights 1-2-1/2-4-2/1-2-1, sum width DATA_W+4, result = sum>>4, truncated.
  - MIN / MAX: over all 9 taps.
  - BYPASS: centre tap.
- start while busy: ignored. in_valid in IDLE, FLUSH or DONE: ignored, with no state change.
- mode changes mid-frame have no effect.
- rst mid-frame aborts immediately. No done pulse and no further out_valid are produced, and the next start begins a clean frame.

## Timing
- out_valid asserts exactly 2 cycles after the advance that produces it: stage 1 registers the window, stage 2 registers the result.
- First output (0,0) appears 2 cycles after accepted input index IMG_W+1.
- Throughput: one pixel per clock when in_valid is held high. FLUSH produces one output per clock.
- Exactly IMG_W·IMG_H out_valid strobes per frame.
- done is high the cycle after the last out_valid. busy falls in the same cycle as done.
- Minimum frame length with no gaps: IMG_W·IMG_H + IMG_W+1 + 3 cycles from start.

## Structure
- Package window_filter_pkg:
  - mode enum (GAUSS, MIN, MAX, BYPASS)
  - state enum (IDLE, RUN, FLUSH, DONE)
  - GAUSS_SHIFT=4 constant
- Sub-module window_line_buffer: parameterised DATA_W/IMG_W shift line buffer with advance enable, outputting the 3x3 taps.
- Top level holds the FSM, row/column counters of the output position (used for the border flag, which is pipelined with the window), and the operator/result stage.

## Test plan
All scenarios use IMG_W=4, IMG_H=4, DATA_W=8.
- Constant 100 frame, GAUSS, in_valid held → 16 outputs all 100; first out_valid 2 cycles after input index 5; done the cycle after the 16th output.
- Ramp pixel=4r+c, MAX → interior (1,1)=10, (1,2)=11, (2,1)=14, (2,2)=15; border outputs equal their input values.
- Same ramp, MIN → interior (1,1)=0, (1,2)=1, (2,1)=4, (2,2)=5; BYPASS → output equals input for all 16.
- Impulse 255 at (1,1), rest 0, GAUSS → (1,1)=63, (1,2)=31, (2,1)=31, (2,2)=15; border pixels 0 except (1,1) neighbours unaffected.
- Random in_valid gaps plus start pulses while busy, and a mode change mid-frame → results identical to the gap-free run; exactly 16 outputs and one done.
- rst asserted after 7 accepted pixels → all outputs 0 at once, no done, busy low; a following clean frame reproduces the first scenario exactly.

Source files
------------

// File: rtl/window_filter_pkg.sv
// Shared types and constants for the streaming 3x3 window filter.
package window_filter_pkg;

    typedef enum logic [1:0] {
        MODE_GAUSS  = 2'd0,
        MODE_MIN    = 2'd1,
        MODE_MAX    = 2'd2,
        MODE_BYPASS = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int GAUSS_SHIFT = 4;

    // Gaussian weight of a tap, taps numbered row-major 0..8 with 4 at the centre.
    function automatic logic [3:0] gauss_weight(input int tap);
        case (tap)
            0, 2, 6, 8: gauss_weight = 4'd1;
            1, 3, 5, 7: gauss_weight = 4'd2;
            4:          gauss_weight = 4'd4;
            default:    gauss_weight = 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/window_filter_stream_line_buffer.sv
// Two IMG_W-deep shift line buffers feeding a 3x3 register window; everything moves on adv.
module window_line_buffer #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   adv,
    input  logic [DATA_W-1:0]      pixel,
    output logic [8:0][DATA_W-1:0] taps
);

    logic [IMG_W-1:0][DATA_W-1:0] lb1_r;
    logic [IMG_W-1:0][DATA_W-1:0] lb0_r;
    logic [2:0][2:0][DATA_W-1:0]  win_r;

    // Row 2 is the newest line, column 2 the newest pixel; older rows come out of the line buffers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lb1_r <= '0;
            lb0_r <= '0;
            win_r <= '0;
        end else if (adv) begin
            lb1_r <= {lb1_r[IMG_W-2:0], pixel};
            lb0_r <= {lb0_r[IMG_W-2:0], lb1_r[IMG_W-1]};
            for (int r = 0; r < 3; r++) begin
                win_r[r][0] <= win_r[r][1];
                win_r[r][1] <= win_r[r][2];
            end
            win_r[2][2] <= pixel;
            win_r[1][2] <= lb1_r[IMG_W-1];
            win_r[0][2] <= lb0_r[IMG_W-1];
        end else begin
            lb1_r <= lb1_r;
            lb0_r <= lb0_r;
            win_r <= win_r;
        end
    end

    assign taps = win_r;

endmodule

// File: rtl/window_filter_stream.sv
// Raster-order 3x3 window filter: FSM, output-position tracking and the two-stage operator pipeline.
module window_filter_stream
    import window_filter_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_pixel,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_pixel,
    output logic              busy,
    output logic              done
);

    localparam int NPIX  = IMG_W * IMG_H;
    localparam int CNT_W = $clog2(NPIX + IMG_W + 2);
    localparam int ROW_W = $clog2(IMG_H);
    localparam int COL_W = $clog2(IMG_W);
    localparam int SUM_W = DATA_W + 4;
    localparam logic [CNT_W-1:0] FIRST_OUT = CNT_W'(IMG_W + 1);
    localparam logic [CNT_W-1:0] LAST_IN   = CNT_W'(NPIX - 1);
    localparam logic [CNT_W-1:0] LAST_ADV  = CNT_W'(NPIX + IMG_W);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_W - 1);

    state_t                   state_r, state_s;
    mode_t                    mode_r;
    logic [CNT_W-1:0]         adv_cnt_r;
    logic [ROW_W-1:0]         row_r;
    logic [COL_W-1:0]         col_r;
    logic                     s1_valid_r, s1_border_r;
    logic                     out_valid_r, busy_r, done_r;
    logic [DATA_W-1:0]        out_pixel_r;
    logic [8:0][DATA_W-1:0]   taps_s;
    logic                     start_ok_s, accept_s, adv_s, out_ok_s, border_s, done_s;
    logic [DATA_W-1:0]        adv_pixel_s, result_s, min_s, max_s;
    logic [SUM_W-1:0]         sum_s;

    assign start_ok_s  = (state_r == ST_IDLE) && start;
    assign accept_s    = (state_r == ST_RUN) && in_valid;
    assign adv_s       = accept_s || (state_r == ST_FLUSH);
    assign out_ok_s    = adv_s && (adv_cnt_r >= FIRST_OUT);
    assign done_s      = (state_r == ST_DONE) && !s1_valid_r;
    assign adv_pixel_s = accept_s ? in_pixel : {DATA_W{1'b0}};
    assign border_s    = (row_r == '0) || (row_r == ROW_LAST) ||
                         (col_r == '0) || (col_r == COL_LAST);

    window_line_buffer #(
        .DATA_W (DATA_W),
        .IMG_W  (IMG_W)
    ) u_line_buffer (
        .clk   (clk),
        .rst   (rst),
        .adv   (adv_s),
        .pixel (adv_pixel_s),
        .taps  (taps_s)
    );

    // Next-state logic; DONE holds until the last window has left stage 1.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE:  if (start) state_s = ST_RUN; else state_s = state_r;
            ST_RUN:   if (accept_s && (adv_cnt_r == LAST_IN)) state_s = ST_FLUSH; else state_s = state_r;
            ST_FLUSH: if (adv_cnt_r == LAST_ADV) state_s = ST_DONE; else state_s = state_r;
            ST_DONE:  if (!s1_valid_r) state_s = ST_IDLE; else state_s = state_r;
            default:  state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= ST_IDLE;
        else     state_r <= state_s;
    end

    // Advance counter, output row/column and the mode latched at frame start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            adv_cnt_r <= '0;
            row_r     <= '0;
            col_r     <= '0;
            mode_r    <= MODE_GAUSS;
        end else if (start_ok_s) begin
            adv_cnt_r <= '0;
            row_r     <= '0;
            col_r     <= '0;
            mode_r    <= mode_t'(mode);
        end else begin
            if (adv_s) adv_cnt_r <= adv_cnt_r + CNT_W'(1);
            else       adv_cnt_r <= adv_cnt_r;
            if (out_ok_s && (col_r == COL_LAST)) begin
                col_r <= '0;
                row_r <= row_r + ROW_W'(1);
            end else if (out_ok_s) begin
                col_r <= col_r + COL_W'(1);
                row_r <= row_r;
            end else begin
                col_r <= col_r;
                row_r <= row_r;
            end
        end
    end

    // Stage 1 flags travel alongside the window registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_r  <= 1'b0;
            s1_border_r <= 1'b0;
        end else begin
            s1_valid_r  <= out_ok_s;
            s1_border_r <= out_ok_s ? border_s : s1_border_r;
        end
    end

    // Operator on the current window; border positions pass the centre through.
    always_comb begin
        sum_s = '0;
        min_s = taps_s[0];
        max_s = taps_s[0];
        for (int i = 0; i < 9; i++) begin
            sum_s = sum_s + SUM_W'(taps_s[i]) * SUM_W'(gauss_weight(i));
            if (taps_s[i] < min_s) min_s = taps_s[i]; else min_s = min_s;
            if (taps_s[i] > max_s) max_s = taps_s[i]; else max_s = max_s;
        end
        result_s = taps_s[4];
        if (s1_border_r) begin
            result_s = taps_s[4];
        end else begin
            case (mode_r)
                MODE_GAUSS:  result_s = DATA_W'(sum_s >> GAUSS_SHIFT);
                MODE_MIN:    result_s = min_s;
                MODE_MAX:    result_s = max_s;
                MODE_BYPASS: result_s = taps_s[4];
                default:     result_s = taps_s[4];
            endcase
        end
    end

    // Stage 2 result and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_pixel_r <= '0;
            done_r      <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            out_valid_r <= s1_valid_r;
            out_pixel_r <= s1_valid_r ? result_s : out_pixel_r;
            done_r      <= done_s;
            if (start_ok_s)  busy_r <= 1'b1;
            else if (done_s) busy_r <= 1'b0;
            else             busy_r <= busy_r;
        end
    end

    assign out_valid = out_valid_r;
    assign out_pixel = out_pixel_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_window_filter_stream.sv
// Randomised scoreboard bench for window_filter_stream on a 4x4 frame.
module tb_window_filter_stream;

    localparam int DW   = 8;
    localparam int W    = 4;
    localparam int H    = 4;
    localparam int NPIX = W * H;

    logic          clk = 1'b0;
    logic          rst, start, in_valid;
    logic [1:0]    mode;
    logic [DW-1:0] in_pixel;
    logic          out_valid, busy, done;
    logic [DW-1:0] out_pixel;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] frame_px[NPIX];
    bit clr_stats = 1'b0;
    int out_cnt, done_cnt, first_cyc, last_cyc, done_cyc;
    int start_cyc, acc_first;

    window_filter_stream #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_pixel  (in_pixel),
        .out_valid (out_valid),
        .out_pixel (out_pixel),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: 3x3 neighbourhood of the frame in 2-D coordinates.
    function automatic int ref_px(input int r, input int c, input logic [1:0] m);
        int sum, mn, mx, v, wr, wc;
        if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return int'(frame_px[r*W+c]);
        sum = 0; mn = 1 << DW; mx = -1;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                v  = int'(frame_px[(r+dr)*W + c + dc]);
                wr = (dr == 0) ? 2 : 1;
                wc = (dc == 0) ? 2 : 1;
                sum += v * wr * wc;
                if (v < mn) mn = v;
                if (v > mx) mx = v;
            end
        end
        case (m)
            2'd0:    return sum / 16;
            2'd1:    return mn;
            2'd2:    return mx;
            default: return int'(frame_px[r*W+c]);
        endcase
    endfunction

    // Monitor: pops the scoreboard on every out_valid and records output timing.
    always @(negedge clk) begin
        logic [DW-1:0] e;
        if (clr_stats) begin
            out_cnt = 0; done_cnt = 0; first_cyc = -1; last_cyc = -1; done_cyc = -1;
        end else if (!rst) begin
            if (out_valid) begin
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                if (exp_q.size() == 0) begin
                    chk("unexpected_out_valid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("pixel_%0d", out_cnt), int'(out_pixel), int'(e));
                end
                out_cnt++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic clear_stats();
        clr_stats = 1'b1;
        @(posedge clk); #1;
        clr_stats = 1'b0;
    endtask

    task automatic drive_frame(input logic [1:0] m, input bit noisy, input bit timing);
        int k;
        clear_stats();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                exp_q.push_back(DW'(ref_px(r, c, m)));
        start = 1'b1; mode = m; start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", int'(busy), 1);
        k = 0;
        while (k < NPIX) begin
            if (noisy && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                in_pixel = DW'($urandom);
                start    = 1'($urandom);
                mode     = 2'($urandom);
            end else begin
                in_valid = 1'b1;
                in_pixel = frame_px[k];
                start    = noisy ? 1'($urandom) : 1'b0;
                if (k == W + 1) acc_first = cyc;
                k++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0; start = 1'b0;
        if (noisy) begin
            for (int i = 0; i < 4; i++) begin
                in_valid = 1'b1; in_pixel = DW'($urandom); start = 1'b1; mode = 2'($urandom);
                @(posedge clk); #1;
            end
            in_valid = 1'b0; start = 1'b0;
        end
        for (int i = 0; i < 300 && done_cnt == 0; i++) begin
            @(posedge clk); #1;
        end
        repeat (4) @(posedge clk);
        #1;
        chk("done_count", done_cnt, 1);
        chk("out_count", out_cnt, NPIX);
        chk("scoreboard_empty", exp_q.size(), 0);
        chk("done_after_last_out", done_cyc, last_cyc + 1);
        chk("busy_low_at_end", int'(busy), 0);
        if (timing) begin
            chk("first_out_latency", first_cyc, acc_first + 2);
            chk("frame_length", done_cyc, start_cyc + NPIX + W + 1 + 3);
        end
        exp_q.delete();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mode = 2'd0; in_valid = 1'b0; in_pixel = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_out_pixel", int'(out_pixel), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < NPIX; i++) frame_px[i] = DW'(100);
        drive_frame(2'd0, 1'b0, 1'b1);

        for (int i = 0; i < NPIX; i++) frame_px[i] = DW'(i);
        drive_frame(2'd2, 1'b0, 1'b1);
        drive_frame(2'd1, 1'b0, 1'b0);
        drive_frame(2'd3, 1'b0, 1'b0);

        for (int i = 0; i < NPIX; i++) frame_px[i] = '0;
        frame_px[W+1] = DW'(255);
        drive_frame(2'd0, 1'b0, 1'b0);

        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < NPIX; i++) frame_px[i] = DW'($urandom_range(0, 255));
            drive_frame(2'(f), 1'b1, 1'b0);
        end

        // Abort mid-frame after 7 accepted pixels.
        for (int i = 0; i < NPIX; i++) frame_px[i] = DW'(100);
        clear_stats();
        start = 1'b1; mode = 2'd0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1; in_pixel = frame_px[i];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("abort_out_valid", int'(out_valid), 0);
        chk("abort_out_pixel", int'(out_pixel), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk("abort_no_done", done_cnt, 0);
        chk("abort_no_out", out_cnt, 0);
        chk("abort_busy_idle", int'(busy), 0);
        drive_frame(2'd0, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
